// File: rtl/disk_sector_buf.sv
// disk_sector_buf: SD sector staging buffers for a VHD-backed disk.
// Two strobes from the SD clock domain are resynchronised into clk_ram;
// each rising edge moves one byte. Reads fill a 256x16 sector buffer, or the
// 128x32 header buffer while conf=1. Writes stream bytes from a separate
// 256x16 buffer that the host side fills with word writes.
module disk_sector_buf (
  input  logic        clk_ram,
  input  logic        reset,
  input  logic        sd_ack,
  input  logic        conf,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_strobe,
  input  logic        sd_din_strobe,
  output logic [7:0]  sd_din,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic [7:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_en,
  input  logic [6:0]  hdr_addr,
  output logic [31:0] hdr_data,
  output logic [31:0] hdr_sig,
  output logic [7:0]  hdr_ver,
  output logic [9:0]  byte_cnt,
  output logic        sector_done
);

  // Strobe synchronizers: s1/s2 are the 2-flop chain, s3 is edge history.
  logic r_do_s1, r_do_s2, r_do_s3;
  logic r_di_s1, r_di_s2, r_di_s3;

  logic [9:0] r_cnt;
  logic       r_done;
  logic [7:0] r_hdr [5];

  // Write-side emit pipeline state.
  logic [9:0]  r_cnt_d;
  logic        r_ack_d;
  logic        r_upd;
  logic        r_sel;
  logic [15:0] r_wq;
  logic [7:0]  r_din;

  // Buffers, byte-lane addressable.
  logic [1:0][7:0] r_rbuf [256];
  logic [3:0][7:0] r_hbuf [128];
  logic [15:0]     r_wbuf [256];

  logic w_dout_ev, w_din_ev, w_take, w_rd_take, w_chg;

  // A read edge wins a same-cycle collision; both just cost one count.
  // Bit 9 set means the counter sits at 512 and further events are ignored.
  assign w_dout_ev = r_do_s2 & ~r_do_s3;
  assign w_din_ev  = r_di_s2 & ~r_di_s3;
  assign w_take    = sd_ack & (w_dout_ev | w_din_ev) & ~r_cnt[9];
  assign w_rd_take = w_take & w_dout_ev;
  // Refresh sd_din whenever the count moves or a transfer starts.
  assign w_chg     = (r_cnt != r_cnt_d) | (sd_ack & ~r_ack_d);

  // Synchronizers and edge history.
  always_ff @(posedge clk_ram) begin
    if (reset) begin
      r_do_s1 <= 1'b0; r_do_s2 <= 1'b0; r_do_s3 <= 1'b0;
      r_di_s1 <= 1'b0; r_di_s2 <= 1'b0; r_di_s3 <= 1'b0;
    end else begin
      r_do_s1 <= sd_dout_strobe; r_do_s2 <= r_do_s1; r_do_s3 <= r_do_s2;
      r_di_s1 <= sd_din_strobe;  r_di_s2 <= r_di_s1; r_di_s3 <= r_di_s2;
    end
  end

  // Byte counter, saturating at 512, cleared while sd_ack is low.
  always_ff @(posedge clk_ram) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_take & (r_cnt == 10'd511);
      if (!sd_ack)
        r_cnt <= '0;
      else if (w_take)
        r_cnt <= r_cnt + 10'd1;
    end
  end

  // Header registers: the first five header bytes, held for hdr_sig/hdr_ver.
  always_ff @(posedge clk_ram) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) r_hdr[i] <= '0;
    end else if (w_rd_take && conf && r_cnt < 10'd5) begin
      r_hdr[r_cnt[2:0]] <= sd_dout;
    end
  end

  // Read and header buffers: byte-lane writes, registered reads. No reset.
  always_ff @(posedge clk_ram) begin
    if (w_rd_take && !conf) r_rbuf[r_cnt[8:1]][r_cnt[0]] <= sd_dout;
    if (w_rd_take && conf)  r_hbuf[r_cnt[8:2]][r_cnt[1:0]] <= sd_dout;
    rd_data  <= r_rbuf[rd_addr];
    hdr_data <= r_hbuf[hdr_addr];
  end

  // Write buffer: host word writes, plus the word the SD side is emitting.
  always_ff @(posedge clk_ram) begin
    if (wr_en) r_wbuf[wr_addr] <= wr_data;
    r_wq <= r_wbuf[r_cnt[8:1]];
  end

  // sd_din only reloads one cycle after a count change, so a host write to
  // the word in flight cannot disturb the byte already on the bus.
  always_ff @(posedge clk_ram) begin
    if (reset) begin
      r_cnt_d <= '0;
      r_ack_d <= 1'b0;
      r_upd   <= 1'b0;
      r_sel   <= 1'b0;
      r_din   <= '0;
    end else begin
      r_cnt_d <= r_cnt;
      r_ack_d <= sd_ack;
      r_upd   <= w_chg;
      r_sel   <= r_cnt[0];
      if (r_upd) r_din <= r_sel ? r_wq[15:8] : r_wq[7:0];
    end
  end

  assign sd_din      = r_din;
  assign byte_cnt    = r_cnt;
  assign sector_done = r_done;
  assign hdr_sig     = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3]};
  assign hdr_ver     = r_hdr[4];

endmodule

// File: tb/tb_disk_sector_buf.sv
// Bench for disk_sector_buf: randomized SD byte streams against a byte-level
// reference model; checks are queued and compared by a separate monitor.
module tb_disk_sector_buf;

  logic        clk_ram = 1'b0;
  logic        reset = 1'b1;
  logic        sd_ack = 1'b0;
  logic        conf = 1'b0;
  logic [7:0]  sd_dout = '0;
  logic        sd_dout_strobe = 1'b0;
  logic        sd_din_strobe = 1'b0;
  logic [7:0]  sd_din;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic [6:0]  hdr_addr = '0;
  logic [31:0] hdr_data;
  logic [31:0] hdr_sig;
  logic [7:0]  hdr_ver;
  logic [9:0]  byte_cnt;
  logic        sector_done;

  disk_sector_buf dut (
    .clk_ram(clk_ram), .reset(reset), .sd_ack(sd_ack), .conf(conf),
    .sd_dout(sd_dout), .sd_dout_strobe(sd_dout_strobe),
    .sd_din_strobe(sd_din_strobe), .sd_din(sd_din),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .hdr_addr(hdr_addr), .hdr_data(hdr_data), .hdr_sig(hdr_sig),
    .hdr_ver(hdr_ver), .byte_cnt(byte_cnt), .sector_done(sector_done)
  );

  always #5 clk_ram = ~clk_ram;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  // Count cycles with sector_done high.
  always @(posedge clk_ram) begin
    #1;
    if (sector_done === 1'b1) done_seen++;
  end

  // Monitor: pop pending expectations and compare with DUT outputs.
  chk_t e;
  logic [31:0] act;
  always begin
    @(posedge clk_ram);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0: act = 32'(byte_cnt);
        1: act = 32'(rd_data);
        2: act = hdr_data;
        3: act = hdr_sig;
        4: act = 32'(hdr_ver);
        5: act = 32'(sd_din);
        6: act = 32'(done_seen);
        default: act = 32'(sector_done);
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", e.nm, act, e.exp, $time);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] m_rbuf [256];
  bit          m_rv   [256];
  logic [31:0] m_hbuf [128];
  bit          m_hv   [128];
  logic [15:0] m_wbuf [256];
  logic [7:0]  m_hdr  [5];
  int          m_cnt = 0;
  int          m_done = 0;
  bit          m_ack = 0;
  bit          m_conf = 0;

  function automatic void model_byte(input bit rd, input logic [7:0] b);
    if (m_ack && m_cnt < 512) begin
      if (rd) begin
        if (m_conf) begin
          m_hbuf[m_cnt / 4][8 * (m_cnt % 4) +: 8] = b;
          if (m_cnt % 4 == 3) m_hv[m_cnt / 4] = 1;
          if (m_cnt < 5) m_hdr[m_cnt] = b;
        end else begin
          m_rbuf[m_cnt / 2][8 * (m_cnt % 2) +: 8] = b;
          if (m_cnt % 2 == 1) m_rv[m_cnt / 2] = 1;
        end
      end
      m_cnt++;
      if (m_cnt == 512) m_done++;
    end
  endfunction

  function automatic logic [7:0] m_emit();
    logic [15:0] w;
    w = m_wbuf[(m_cnt % 512) / 2];
    return (m_cnt % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic void push(input string nm, input int sel, input logic [31:0] exp);
    chk_t c;
    c.nm = nm; c.sel = sel; c.exp = exp;
    q.push_back(c);
  endfunction

  task automatic chk(input string nm, input int sel, input logic [31:0] exp);
    push(nm, sel, exp);
    @(posedge clk_ram);
    #3;
  endtask

  task automatic chk_rd(input int a);
    rd_addr = 8'(a);
    @(negedge clk_ram);
    @(negedge clk_ram);
    if (m_rv[a]) chk("rd_data", 1, 32'(m_rbuf[a]));
  endtask

  task automatic chk_hdr(input int a);
    hdr_addr = 7'(a);
    @(negedge clk_ram);
    @(negedge clk_ram);
    if (m_hv[a]) chk("hdr_data", 2, m_hbuf[a]);
  endtask

  // One strobe pulse at a random phase: 2 clocks high, 2+ clocks low.
  task automatic strobe_byte(input bit rd, input bit wr, input logic [7:0] b);
    @(negedge clk_ram);
    #($urandom_range(0, 3));
    sd_dout = b;
    if (rd) sd_dout_strobe = 1'b1;
    if (wr) sd_din_strobe = 1'b1;
    model_byte(rd, b);
    repeat (2) @(negedge clk_ram);
    sd_dout_strobe = 1'b0;
    sd_din_strobe  = 1'b0;
    repeat (2) @(negedge clk_ram);
  endtask

  task automatic set_ack(input bit v);
    @(negedge clk_ram);
    sd_ack = v;
    m_ack  = v;
    if (!v) m_cnt = 0;
    repeat (2) @(negedge clk_ram);
  endtask

  task automatic word_wr(input int a, input logic [15:0] d);
    @(negedge clk_ram);
    wr_addr = 8'(a); wr_data = d; wr_en = 1'b1;
    m_wbuf[a] = d;
    @(negedge clk_ram);
    wr_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] hb [12];
    logic [7:0] exp_din;
    int prev_done;

    for (int i = 0; i < 5; i++) m_hdr[i] = '0;
    for (int i = 0; i < 256; i++) begin
      m_rv[i] = 0;
      m_wbuf[i] = 16'($urandom);
    end
    for (int i = 0; i < 128; i++) m_hv[i] = 0;

    repeat (3) @(negedge clk_ram);
    chk("rst_cnt", 0, 32'd0);
    chk("rst_sig", 3, 32'd0);
    chk("rst_ver", 4, 32'd0);
    chk("rst_din", 5, 32'd0);
    chk("rst_done", 7, 32'd0);
    @(negedge clk_ram);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_ram);
      wr_addr = 8'(i); wr_data = m_wbuf[i]; wr_en = 1'b1;
    end
    @(negedge clk_ram);
    wr_en = 1'b0;

    conf = 1'b0; m_conf = 0;
    set_ack(1);
    for (int i = 0; i < 512; i++) strobe_byte(1, 0, 8'(i));
    chk("sec_cnt", 0, 32'd512);
    n_tests++;
    if (byte_cnt !== 10'd512) begin
      n_fail++;
      $display("FAIL sec_cnt_direct: got %0d expected 512 at %0t", byte_cnt, $time);
    end
    chk("sec_done", 6, 32'(m_done));
    rd_addr = 8'd3;
    repeat (2) @(negedge clk_ram);
    chk("sec_rd3", 1, 32'h0706);
    for (int k = 0; k < 6; k++) chk_rd($urandom_range(0, 255));
    set_ack(0);
    chk("sec_clr", 0, 32'd0);

    hb[0] = 8'h42; hb[1] = 8'h4B; hb[2] = 8'h48; hb[3] = 8'h44; hb[4] = 8'h01;
    hb[5] = 8'($urandom); hb[6] = 8'($urandom); hb[7] = 8'($urandom);
    hb[8] = 8'h10; hb[9] = 8'h00; hb[10] = 8'h00; hb[11] = 8'h00;
    conf = 1'b1; m_conf = 1;
    set_ack(1);
    for (int i = 0; i < 12; i++) strobe_byte(1, 0, hb[i]);
    chk("hdr_sig", 3, 32'h424B4844);
    chk("hdr_ver", 4, 32'h01);
    n_tests++;
    if (hdr_sig !== 32'h424B4844) begin
      n_fail++;
      $display("FAIL hdr_sig_direct: got %h expected 424B4844 at %0t", hdr_sig, $time);
    end
    hdr_addr = 7'd2;
    repeat (2) @(negedge clk_ram);
    chk("hdr_dw2", 2, 32'h00000010);
    chk_hdr(0);
    chk_hdr(1);
    rd_addr = 8'd3;
    repeat (2) @(negedge clk_ram);
    chk("hdr_rd_kept", 1, 32'h0706);
    chk_rd(2);
    set_ack(0);
    conf = 1'b0; m_conf = 0;

    word_wr(0, 16'hA55A);
    word_wr(1, 16'h1234);
    set_ack(1);
    repeat (2) @(negedge clk_ram);
    chk("din0", 5, 32'h5A);
    n_tests++;
    if (sd_din !== 8'h5A) begin
      n_fail++;
      $display("FAIL din0_direct: got %h expected 5A at %0t", sd_din, $time);
    end
    strobe_byte(0, 1, 8'h00);
    repeat (2) @(negedge clk_ram);
    chk("din1", 5, 32'hA5);
    strobe_byte(0, 1, 8'h00);
    repeat (2) @(negedge clk_ram);
    chk("din2", 5, 32'h34);
    strobe_byte(0, 1, 8'h00);
    repeat (2) @(negedge clk_ram);
    chk("din3", 5, 32'h12);
    chk("din_cnt", 0, 32'(m_cnt));
    rd_addr = 8'd0;
    repeat (2) @(negedge clk_ram);
    chk("din_no_rdbuf", 1, 32'(m_rbuf[0]));
    for (int k = 0; k < 5; k++) begin
      strobe_byte(0, 1, 8'($urandom));
      repeat (2) @(negedge clk_ram);
      chk("din_rand", 5, 32'(m_emit()));
    end
    set_ack(0);

    set_ack(1);
    repeat (2) @(negedge clk_ram);
    exp_din = m_emit();
    chk("inflight_pre", 5, 32'(exp_din));
    word_wr(0, 16'hC3D2);
    repeat (3) @(negedge clk_ram);
    chk("inflight_hold", 5, 32'(exp_din));
    strobe_byte(0, 1, 8'h00);
    repeat (2) @(negedge clk_ram);
    chk("inflight_next", 5, 32'hC3);
    set_ack(0);

    set_ack(1);
    strobe_byte(1, 1, 8'h77);
    chk("coll_cnt1", 0, 32'd1);
    strobe_byte(1, 1, 8'h88);
    chk("coll_cnt2", 0, 32'd2);
    chk_rd(0);
    set_ack(0);

    prev_done = m_done;
    set_ack(1);
    for (int i = 0; i < 100; i++) strobe_byte(1, 0, 8'($urandom));
    chk("abort_pre", 0, 32'd100);
    @(negedge clk_ram);
    sd_ack = 1'b0; m_ack = 0; m_cnt = 0;
    @(negedge clk_ram);
    chk("abort_cnt", 0, 32'd0);
    n_tests++;
    if (byte_cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_cnt_direct: got %0d expected 0 at %0t", byte_cnt, $time);
    end
    chk("abort_done", 6, 32'(prev_done));
    chk_rd(0);
    chk_rd(49);
    for (int k = 0; k < 4; k++) chk_rd($urandom_range(1, 48));
    chk_rd(60);

    set_ack(1);
    for (int i = 0; i < 512; i++) strobe_byte(1, 0, 8'($urandom));
    for (int i = 0; i < 8; i++) strobe_byte(1, 0, 8'hEE);
    chk("ovr_cnt", 0, 32'd512);
    chk("ovr_done", 6, 32'(m_done));
    chk_rd(0);
    chk_rd(255);
    set_ack(0);

    conf = 1'b1; m_conf = 1;
    set_ack(1);
    for (int i = 0; i < 300; i++) strobe_byte(1, 0, 8'($urandom));
    chk("rst_pre_cnt", 0, 32'd300);
    chk("rst_pre_sig", 3, {m_hdr[0], m_hdr[1], m_hdr[2], m_hdr[3]});
    @(negedge clk_ram);
    reset = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < 5; i++) m_hdr[i] = '0;
    push("mid_rst_cnt", 0, 32'd0);
    push("mid_rst_din", 5, 32'd0);
    push("mid_rst_sig", 3, 32'd0);
    @(posedge clk_ram);
    #3;
    @(negedge clk_ram);
    reset = 1'b0;
    set_ack(0);
    conf = 1'b0; m_conf = 0;
    chk_hdr(1);
    chk("end_done", 6, 32'(m_done));
    n_tests++;
    if (done_seen != m_done) begin
      n_fail++;
      $display("FAIL end_done_direct: got %0d expected %0d at %0t", done_seen, m_done, $time);
    end

    repeat (3) @(negedge clk_ram);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
